// File: rtl/gate_check_pkg.sv
// Shared types and constants for the AND-gate vector checker.
package gate_check_pkg;
    localparam int NUM_VEC = 4;
    localparam int ERR_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction
endpackage

// File: rtl/gate_vector_checker_if.sv
// Run control, stimulus and result signals of the gate vector checker.
interface gate_vector_checker_if;
    logic                          start;
    logic                          y;
    logic                          a;
    logic                          b;
    logic                          busy;
    logic                          done;
    logic                          pass;
    logic [gate_check_pkg::ERR_W-1:0] err_cnt;
    logic [1:0]                    first_fail_vec;
    logic                          first_fail_y;

    modport master (
        output start, y,
        input  a, b, busy, done, pass, err_cnt, first_fail_vec, first_fail_y
    );

    modport slave (
        input  start, y,
        output a, b, busy, done, pass, err_cnt, first_fail_vec, first_fail_y
    );
endinterface

// File: rtl/gate_vector_checker_vec_seq.sv
// Vector sequencer: vector index, settle down-counter and pass counter.
module vec_seq
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int NUM_PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       settle,
    input  logic       sample,
    output logic [1:0] vec_idx,
    output logic       settle_last,
    output logic       last_vec,
    output logic       last_pass
);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);
    localparam logic [7:0] PASS_LAST   = 8'(NUM_PASSES - 1);
    localparam logic [1:0] VEC_LAST    = 2'(NUM_VEC - 1);

    logic [3:0] settle_cnt;
    logic [7:0] pass_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_idx    <= 2'd0;
            settle_cnt <= 4'd0;
            pass_cnt   <= 8'd0;
        end else if (load) begin
            vec_idx    <= 2'd0;
            settle_cnt <= SETTLE_INIT;
            pass_cnt   <= 8'd0;
        end else if (settle) begin
            settle_cnt <= settle_cnt - 4'd1;
        end else if (sample) begin
            if (!last_vec) begin
                vec_idx    <= vec_idx + 2'd1;
                settle_cnt <= SETTLE_INIT;
            end else if (!last_pass) begin
                vec_idx    <= 2'd0;
                pass_cnt   <= pass_cnt + 8'd1;
                settle_cnt <= SETTLE_INIT;
            end else begin
                // end of run: park on vector 00 so a/b return low in DONE
                vec_idx    <= 2'd0;
            end
        end
    end

    assign settle_last = (settle_cnt == 4'd1);
    assign last_vec    = (vec_idx == VEC_LAST);
    assign last_pass   = (pass_cnt == PASS_LAST);
endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps a 2-input AND gate through all vectors and counts mismatches on y.
// Define GATE_CHECKER_LOG_EN to capture the first failing vector and its y value.
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int NUM_PASSES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_vector_checker_if.slave  bus
);
    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             mismatch;
    logic [1:0]       vec_idx;
    logic             settle_last;
    logic             last_vec;
    logic             last_pass;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       fail_vec;
    logic             fail_y;

    assign accept   = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign mismatch = (state == ST_SAMPLE) && (bus.y != (vec_idx[1] & vec_idx[0]));

    vec_seq #(
        .SETTLE_CYC (SETTLE_CYC),
        .NUM_PASSES (NUM_PASSES)
    ) u_vec_seq (
        .clk         (clk),
        .rst         (rst),
        .load        (accept),
        .settle      (state == ST_SETTLE),
        .sample      (state == ST_SAMPLE),
        .vec_idx     (vec_idx),
        .settle_last (settle_last),
        .last_vec    (last_vec),
        .last_pass   (last_pass)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (accept) state_nxt = ST_SETTLE;
            ST_SETTLE:        if (settle_last) state_nxt = ST_SAMPLE;
            ST_SAMPLE:        state_nxt = (last_vec && last_pass) ? ST_DONE : ST_SETTLE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy           = (state == ST_SETTLE) || (state == ST_SAMPLE);
        bus.done           = (state == ST_DONE);
        bus.pass           = (state == ST_DONE) && (err_cnt == '0);
        bus.a              = vec_idx[1];
        bus.b              = vec_idx[0];
        bus.err_cnt        = err_cnt;
        bus.first_fail_vec = fail_vec;
        bus.first_fail_y   = fail_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           err_cnt <= '0;
        else if (accept)   err_cnt <= '0;
        else if (mismatch) err_cnt <= sat_inc(err_cnt);
    end

`ifdef GATE_CHECKER_LOG_EN
    // err_cnt still zero marks the first mismatch of the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_vec <= 2'd0;
            fail_y   <= 1'b0;
        end else if (accept) begin
            fail_vec <= 2'd0;
            fail_y   <= 1'b0;
        end else if (mismatch && (err_cnt == '0)) begin
            fail_vec <= vec_idx;
            fail_y   <= bus.y;
        end
    end
`else
    assign fail_vec = 2'd0;
    assign fail_y   = 1'b0;
`endif
endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized self-checking bench for gate_vector_checker against a sweep-level model.
module tb_gate_vector_checker;
    localparam int S0 = 1;
    localparam int P0 = 1;
    localparam int S1 = 2;
    localparam int P1 = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    gate_vector_checker_if bus0 ();
    gate_vector_checker_if bus1 ();

    gate_vector_checker dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    gate_vector_checker #(
        .SETTLE_CYC (S1),
        .NUM_PASSES (P1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    // gate behaviours: 0 AND, 1 stuck-0, 2 OR, 3 NAND, 4 AND with per-vector flips
    function automatic logic y_of(input int mode, input logic [3:0] mask, input int v);
        logic av, bv;
        av = v[1];
        bv = v[0];
        case (mode)
            0:       return av & bv;
            1:       return 1'b0;
            2:       return av | bv;
            3:       return ~(av & bv);
            default: return (av & bv) ^ mask[v];
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus0.start = 1'b0; bus0.y = 1'b0;
        bus1.start = 1'b0; bus1.y = 1'b0;
        #12;
        total++;
        if ({bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt,
             bus0.first_fail_vec, bus0.first_fail_y} !== 16'd0) begin
            bad++;
            $display("FAIL reset0: got a=%b b=%b busy=%b done=%b pass=%b err=%0d want all 0",
                     bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt);
        end
        total++;
        if ({bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt,
             bus1.first_fail_vec, bus1.first_fail_y} !== 16'd0) begin
            bad++;
            $display("FAIL reset1: got busy=%b done=%b err=%0d want all 0",
                     bus1.busy, bus1.done, bus1.err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
            bad++;
            $display("FAIL idle: got busy=%b done=%b want 0 0", bus0.busy, bus0.done);
        end
    endtask

    // One full run on dut0; dup_start pulses start at cycle 3, end_start during the final SAMPLE.
    task automatic run_check(input string name, input int mode, input logic [3:0] mask,
                             input bit dup_start, input bit end_start);
        int   len;
        int   n;
        int   exp_err;
        logic [1:0] fv;
        logic fy;
        bit   seen;
        len = 4 * P0 * (S0 + 1);
        n = 0; seen = 0; fv = 2'd0; fy = 1'b0;
        for (int p = 0; p < P0; p++)
            for (int v = 0; v < 4; v++)
                if (y_of(mode, mask, v) !== (v == 3)) begin
                    n++;
                    if (!seen) begin
                        seen = 1; fv = 2'(v); fy = y_of(mode, mask, v);
                    end
                end
        exp_err = (n > 255) ? 255 : n;
`ifndef GATE_CHECKER_LOG_EN
        fv = 2'd0; fy = 1'b0;
`endif
        bus0.start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < len; c++) begin
            int v;
            if (c > 0) @(negedge clk);
            v = (c / (S0 + 1)) % 4;
            bus0.start = (dup_start && c == 3) || (end_start && c == len - 1);
            bus0.y = ((c % (S0 + 1)) == S0) ? y_of(mode, mask, v) : 1'($urandom);
            total++;
            if (bus0.a !== v[1] || bus0.b !== v[0] || bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
                bad++;
                $display("FAIL %s cyc%0d: got ab=%b%b busy=%b done=%b want ab=%0d busy=1 done=0",
                         name, c, bus0.a, bus0.b, bus0.busy, bus0.done, v);
            end
        end
        @(negedge clk);
        bus0.start = 1'b0;
        total++;
        if (bus0.done !== 1'b1 || bus0.busy !== 1'b0 || bus0.a !== 1'b0 || bus0.b !== 1'b0) begin
            bad++;
            $display("FAIL %s end: got done=%b busy=%b ab=%b%b want done=1 busy=0 ab=00",
                     name, bus0.done, bus0.busy, bus0.a, bus0.b);
        end
        total++;
        if (bus0.err_cnt !== 8'(exp_err) || bus0.pass !== (exp_err == 0)) begin
            bad++;
            $display("FAIL %s result: got err=%0d pass=%b want err=%0d pass=%b",
                     name, bus0.err_cnt, bus0.pass, exp_err, (exp_err == 0));
        end
        total++;
        if (bus0.first_fail_vec !== fv || bus0.first_fail_y !== fy) begin
            bad++;
            $display("FAIL %s log: got vec=%b y=%b want vec=%b y=%b",
                     name, bus0.first_fail_vec, bus0.first_fail_y, fv, fy);
        end
        @(negedge clk);
        total++;
        if (bus0.done !== 1'b1 || bus0.err_cnt !== 8'(exp_err)) begin
            bad++;
            $display("FAIL %s hold: got done=%b err=%0d want done=1 err=%0d",
                     name, bus0.done, bus0.err_cnt, exp_err);
        end
    endtask

    task automatic test_gate_models();
        run_check("and",   0, 4'h0, 1'b0, 1'b0);
        run_check("stuck0", 1, 4'h0, 1'b0, 1'b0);
        run_check("or",    2, 4'h0, 1'b0, 1'b0);
        run_check("nand",  3, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_check("dup_and", 0, 4'h0, 1'b1, 1'b0);
        run_check("dup_or",  2, 4'h0, 1'b1, 1'b0);
        run_check("end_start", 1, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic test_rst_mid_run();
        bus0.start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            bus0.start = 1'b0;
            bus0.y = ((c % (S0 + 1)) == S0) ? y_of(3, 4'h0, (c / (S0 + 1)) % 4) : 1'b0;
        end
        @(negedge clk);
        total++;
        if (bus0.err_cnt !== 8'd1 || bus0.b !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: got err=%0d b=%b want err=1 b=1", bus0.err_cnt, bus0.b);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus0.a !== 1'b0 || bus0.b !== 1'b0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0 ||
            bus0.pass !== 1'b0 || bus0.err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid: got ab=%b%b busy=%b done=%b pass=%b err=%0d want all 0",
                     bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_check("after_rst", 0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int mode;
            logic [3:0] mask;
            mode = $urandom_range(0, 4);
            mask = 4'($urandom);
            run_check("random", mode, mask, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_saturation();
        int len;
        logic [1:0] fv;
        logic fy;
        len = 4 * P1 * (S1 + 1);
`ifdef GATE_CHECKER_LOG_EN
        fv = 2'b00; fy = 1'b1;
`else
        fv = 2'b00; fy = 1'b0;
`endif
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < len; c++) begin
            int v;
            if (c > 0) @(negedge clk);
            bus1.start = 1'b0;
            v = (c / (S1 + 1)) % 4;
            bus1.y = ((c % (S1 + 1)) == S1) ? y_of(3, 4'h0, v) : 1'($urandom);
            total++;
            if (bus1.a !== v[1] || bus1.b !== v[0] || bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
                bad++;
                $display("FAIL sat cyc%0d: got ab=%b%b busy=%b done=%b want ab=%0d busy=1 done=0",
                         c, bus1.a, bus1.b, bus1.busy, bus1.done, v);
            end
        end
        @(negedge clk);
        total++;
        if (bus1.done !== 1'b1 || bus1.err_cnt !== 8'd255 || bus1.pass !== 1'b0) begin
            bad++;
            $display("FAIL sat end: got done=%b err=%0d pass=%b want done=1 err=255 pass=0",
                     bus1.done, bus1.err_cnt, bus1.pass);
        end
        total++;
        if (bus1.first_fail_vec !== fv || bus1.first_fail_y !== fy) begin
            bad++;
            $display("FAIL sat log: got vec=%b y=%b want vec=%b y=%b",
                     bus1.first_fail_vec, bus1.first_fail_y, fv, fy);
        end
    endtask

    initial begin
        test_reset();
        test_gate_models();
        test_start_while_busy();
        test_rst_mid_run();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
